// File: rtl/fifo_burst_reader.sv
// Drains a synchronous FIFO into valid/ready bursts (threshold or timeout flush); first beat 2 (RD_LAT=0) or 3 (RD_LAT=1) cycles after trigger.
// Backpressure: at most 2 words in flight beyond accepted beats; m_data/m_last hold while stalled.
module fifo_burst_reader #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 128,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 64,
  parameter int RD_LAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     fifo_rd_en,
  input  logic [WIDTH-1:0]         fifo_rd_data,
  input  logic                     fifo_empty,
  input  logic [$clog2(DEPTH)-1:0] fifo_data_cnt,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_last,
  output logic [$clog2(DEPTH):0]   burst_len_o,
  output logic                     busy
);

  localparam int CW = $clog2(DEPTH);
  localparam int LW = CW + 1;
  localparam int TW = $clog2(TIMEOUT + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [LW-1:0] BLEN   = LW'(BURST_LEN);
  localparam logic [TW-1:0] TMO    = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_M1 = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]       state;
  logic [TW-1:0]    timer;
  logic [LW-1:0]    len;
  logic [LW-1:0]    issued;
  logic [LW-1:0]    sent;
  logic [LW-1:0]    avail;
  logic [WIDTH-1:0] buf0;
  logic [WIDTH-1:0] buf1;
  logic [1:0]       buf_cnt;
  logic             rd_pend;
  logic             outstanding;
  logic [2:0]       occ;
  logic             pop;
  logic             push;
  logic             start;
  logic [LW-1:0]    start_len;

  // A zero count with a non-empty flag means the FIFO is completely full.
  assign avail = (!fifo_empty && fifo_data_cnt == '0) ? LW'(DEPTH) : {1'b0, fifo_data_cnt};

  always_comb begin
    start     = 1'b0;
    start_len = BLEN;
    if (state == S_IDLE) begin
      if (avail >= BLEN) begin
        start = 1'b1;
      end else if (TIMEOUT != 0 && timer == TMO_M1 && !fifo_empty) begin
        start     = 1'b1;
        start_len = avail;
      end
    end
  end

  assign m_valid     = (buf_cnt != 2'd0);
  assign m_data      = buf0;
  assign m_last      = m_valid && (sent == len - 1'b1);
  assign pop         = m_valid && m_ready;
  assign busy        = (state != S_IDLE);
  assign outstanding = (RD_LAT == 1) ? rd_pend : 1'b0;

  // Words already buffered or in flight, net of the beat leaving this cycle.
  assign occ = {1'b0, buf_cnt} + {2'b00, outstanding} - {2'b00, pop};

  assign fifo_rd_en = (state == S_BURST) && (issued < len) && !fifo_empty && (occ < 3'd2);
  assign push       = (RD_LAT == 1) ? rd_pend : fifo_rd_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      len         <= '0;
      issued      <= '0;
      sent        <= '0;
      burst_len_o <= '0;
      buf0        <= '0;
      buf1        <= '0;
      buf_cnt     <= 2'd0;
      rd_pend     <= 1'b0;
    end else begin
      rd_pend <= (RD_LAT == 1) && fifo_rd_en;
      if (fifo_rd_en) issued <= issued + 1'b1;
      if (pop)        sent   <= sent + 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_BURST;
            len         <= start_len;
            burst_len_o <= start_len;
            timer       <= '0;
          end else if (fifo_empty) begin
            timer <= '0;
          end else if (timer != TMO) begin
            timer <= timer + 1'b1;
          end
        end
        S_BURST: begin
          if (fifo_rd_en && (issued + 1'b1 == len)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && m_last) begin
            state  <= S_IDLE;
            timer  <= '0;
            issued <= '0;
            sent   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase

      case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) buf0 <= fifo_rd_data;
          else                 buf1 <= fifo_rd_data;
          buf_cnt <= buf_cnt + 1'b1;
        end
        2'b01: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 1'b1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf0 <= fifo_rd_data;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench: FIFO models feed an RD_LAT=1 instance (scoreboarded) and an RD_LAT=0 instance (latency/data).
module tb_fifo_burst_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] len;
    logic       last;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   beats_a = 0;
  int   fifo_err = 0;
  logic rnd_mode = 1'b0;

  // Instance A: RD_LAT = 1
  logic       rd_en_a, empty_a, m_valid_a, m_last_a, busy_a;
  logic [7:0] rd_data_a, m_data_a, blen_a;
  logic [6:0] dcnt_a;
  logic       m_ready_a = 1'b1;
  // Instance B: RD_LAT = 0
  logic       rd_en_b, empty_b, m_valid_b, m_last_b, busy_b;
  logic [7:0] rd_data_b, m_data_b, blen_b;
  logic [6:0] dcnt_b;
  logic       m_ready_b = 1'b1;

  fifo_burst_reader #(.WIDTH(8), .DEPTH(128), .BURST_LEN(16), .TIMEOUT(64), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .fifo_rd_en(rd_en_a), .fifo_rd_data(rd_data_a),
    .fifo_empty(empty_a), .fifo_data_cnt(dcnt_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
    .m_data(m_data_a), .m_last(m_last_a), .burst_len_o(blen_a), .busy(busy_a));

  fifo_burst_reader #(.WIDTH(8), .DEPTH(128), .BURST_LEN(16), .TIMEOUT(64), .RD_LAT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_rd_en(rd_en_b), .fifo_rd_data(rd_data_b),
    .fifo_empty(empty_b), .fifo_data_cnt(dcnt_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
    .m_data(m_data_b), .m_last(m_last_b), .burst_len_o(blen_b), .busy(busy_b));

  // Behavioural FIFOs; a write request may load many words in one edge.
  logic [7:0] mem_a [128];
  logic [7:0] mem_b [128];
  logic [6:0] wp_a, rp_a, wp_b, rp_b;
  int         cnt_a, cnt_b;
  int         wr_n_a = 0, wr_n_b = 0;
  logic [7:0] wr_base_a = 8'h00, wr_base_b = 8'h00;

  assign empty_a   = (cnt_a == 0);
  assign dcnt_a    = 7'(cnt_a);
  assign empty_b   = (cnt_b == 0);
  assign dcnt_b    = 7'(cnt_b);
  assign rd_data_b = mem_b[rp_b];

  always @(posedge clk) begin
    if (!rst_n) begin
      wp_a <= '0; rp_a <= '0; cnt_a <= 0; rd_data_a <= '0;
      wp_b <= '0; rp_b <= '0; cnt_b <= 0;
    end else begin
      if (rd_en_a) begin
        if (cnt_a == 0) fifo_err <= fifo_err + 1;
        else begin rd_data_a <= mem_a[rp_a]; rp_a <= rp_a + 7'd1; end
      end
      if (rd_en_b) begin
        if (cnt_b == 0) fifo_err <= fifo_err + 1;
        else rp_b <= rp_b + 7'd1;
      end
      for (int k = 0; k < wr_n_a; k++) mem_a[wp_a + 7'(k)] <= wr_base_a + 8'(k);
      for (int k = 0; k < wr_n_b; k++) mem_b[wp_b + 7'(k)] <= wr_base_b + 8'(k);
      wp_a  <= wp_a + 7'(wr_n_a);
      wp_b  <= wp_b + 7'(wr_n_b);
      cnt_a <= cnt_a + wr_n_a - ((rd_en_a && cnt_a != 0) ? 1 : 0);
      cnt_b <= cnt_b + wr_n_b - ((rd_en_b && cnt_b != 0) ? 1 : 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic l, input logic [7:0] len);
    exp_t e;
    e.data = d; e.last = l; e.len = len;
    sb.push_back(e);
  endtask

  task automatic expect_burst(input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) push_exp(base + 8'(k), k == n - 1, 8'(n));
  endtask

  task automatic fifo_write_a(input int n, input logic [7:0] base);
    wr_base_a = base; wr_n_a = n;
    @(posedge clk); #1;
    wr_n_a = 0;
  endtask

  task automatic fifo_write_b(input int n, input logic [7:0] base);
    wr_base_b = base; wr_n_b = n;
    @(posedge clk); #1;
    wr_n_b = 0;
  endtask

  // Cycle index 0 is the cycle right after the write edge.
  task automatic measure(input bit use_b, input logic [7:0] base, input int n,
                         output int t_rd, output int t_v, output int run);
    logic rd, v;
    t_rd = -1; t_v = -1; run = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      rd = use_b ? rd_en_b : rd_en_a;
      v  = use_b ? m_valid_b : m_valid_a;
      if (rd && t_rd < 0) t_rd = k;
      if (v && t_v < 0) t_v = k;
      if (t_v >= 0) begin
        if (!v) break;
        if (use_b) check("b_beat", 32'({m_last_b, m_data_b}), 32'({run == n - 1, base + 8'(run)}));
        run++;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 800; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy_a) break;
    end
    check(name, {31'(sb.size()), busy_a}, 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      m_ready_a = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard monitor for instance A.
  initial begin
    exp_t       e;
    logic       prev_stall = 1'b0, prev_last = 1'b0, busy_chk = 1'b0;
    logic [7:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0; busy_chk = 1'b0;
        continue;
      end
      if (busy_chk) begin
        check("busy_after_last", 32'(busy_a), 32'd0);
        busy_chk = 1'b0;
      end
      if (prev_stall)
        check("stall_hold", 32'({m_valid_a, m_last_a, m_data_a}), 32'({1'b1, prev_last, prev_data}));
      if (m_valid_a && m_ready_a) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'({m_last_a, m_data_a}), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("beat", 32'({blen_a, m_last_a, m_data_a}), 32'(e));
        end
        beats_a++;
        if (m_last_a) busy_chk = 1'b1;
      end
      prev_stall = m_valid_a && !m_ready_a;
      prev_data  = m_data_a;
      prev_last  = m_last_a;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int t_rd, t_v, run, b0, k;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", 32'({rd_en_a, m_valid_a, m_last_a, busy_a, m_data_a, blen_a}), 32'd0);
    check("reset_b", 32'({rd_en_b, m_valid_b, m_last_b, busy_b, m_data_b, blen_b}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full threshold burst
    expect_burst(8'h00, 16);
    fifo_write_a(16, 8'h00);
    measure(1'b0, 8'h00, 16, t_rd, t_v, run);
    check("t1_rd_lat", t_rd, 1);
    check("t1_valid_lat", t_v, 3);
    check("t1_contig", run, 16);
    wait_drain("t1_drain");

    // Timeout flush of 5 words
    expect_burst(8'hA0, 5);
    fifo_write_a(5, 8'hA0);
    measure(1'b0, 8'hA0, 5, t_rd, t_v, run);
    check("t2_rd_lat", t_rd, 64);
    check("t2_valid_lat", t_v, 66);
    check("t2_contig", run, 5);
    wait_drain("t2_drain");

    // 40 words under random backpressure: 16, 16, then timeout 8
    expect_burst(8'h40, 16);
    expect_burst(8'h50, 16);
    expect_burst(8'h60, 8);
    rnd_mode = 1'b1;
    fifo_write_a(40, 8'h40);
    wait_drain("t3_drain");
    rnd_mode = 1'b0;
    @(negedge clk);

    // Completely full FIFO: count reads 0 with empty low
    for (int b = 0; b < 8; b++) expect_burst(8'h80 + 8'(16 * b), 16);
    fifo_write_a(128, 8'h80);
    measure(1'b0, 8'h80, 16, t_rd, t_v, run);
    check("t4_rd_lat", t_rd, 1);
    check("t4_contig", run, 16);
    wait_drain("t4_drain");
    check("t4_fifo_empty", cnt_a, 0);

    // Reset after 7 beats of a burst
    for (int j = 0; j < 7; j++) push_exp(8'h50 + 8'(j), 1'b0, 8'd16);
    b0 = beats_a;
    fifo_write_a(16, 8'h50);
    for (k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (beats_a == b0 + 7) break;
    end
    check("t5_seven_beats", beats_a - b0, 7);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_reset_outputs", 32'({rd_en_a, m_valid_a, m_last_a, busy_a, m_data_a, blen_a}), 32'd0);
    #1 rst_n = 1'b1;
    check("t5_sb_consumed", 32'(sb.size()), 32'd0);
    @(negedge clk);
    expect_burst(8'h60, 16);
    fifo_write_a(16, 8'h60);
    measure(1'b0, 8'h60, 16, t_rd, t_v, run);
    check("t5_rd_lat", t_rd, 1);
    check("t5_valid_lat", t_v, 3);
    check("t5_contig", run, 16);
    wait_drain("t5_drain");

    // Zero-latency FIFO build
    fifo_write_b(16, 8'h30);
    measure(1'b1, 8'h30, 16, t_rd, t_v, run);
    check("t6_rd_lat", t_rd, 1);
    check("t6_valid_lat", t_v, 2);
    check("t6_contig", run, 16);
    @(negedge clk);
    check("t6_blen", 32'({blen_b, busy_b}), 32'({8'd16, 1'b0}));

    repeat (4) @(negedge clk);
    check("fifo_underflow", fifo_err, 0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
